// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers raster position from incoming hsync/vsync, locks onto the
// timing after LOCK_FRAMES clean frames, and reports the first white pixel of each frame.
//
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   hsync_in, vsync_in    incoming sync (active level SYNC_POL)
//   rgb_in[2:0]           incoming pixel {b,g,r}
//   hpos, vpos [9:0]      recovered position of the pixel sampled two clocks earlier
//   rgb_out[2:0]          that pixel, aligned with hpos/vpos
//   display_on            locked and inside the visible window
//   locked                timing lock status
//   frame_done            one-cycle strobe on the vsync edge ending a locked frame
//   ball_valid/x/y        first white pixel of the last completed frame
//   err_count[7:0]        saturating count of timing errors seen while locked
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned SYNC_POL     = 1,
    parameter int unsigned LOCK_FRAMES  = 2,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic [2:0] rgb_out,
    output logic       display_on,
    output logic       locked,
    output logic       frame_done,
    output logic       ball_valid,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC = 10'(H_SYNC_START);
    localparam logic [9:0] V_SYNC = 10'(V_SYNC_START);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic       POL    = 1'(SYNC_POL);

    // Counter must hold TIMEOUT+1 so it can park there without wrapping.
    localparam int unsigned TO_W = $clog2(TIMEOUT + 2);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

    // ---------------- stage 1: input sample and edge history ----------------
    logic       s1_valid_q;
    logic       s1_hs_q, s1_vs_q;   // sync active (polarity removed)
    logic       hs_prev_q, vs_prev_q;
    logic [2:0] s1_rgb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            s1_rgb_q   <= 3'b000;
        end else begin
            s1_valid_q <= 1'b1;
            s1_hs_q    <= (hsync_in == POL);
            s1_vs_q    <= (vsync_in == POL);
            hs_prev_q  <= s1_hs_q;
            vs_prev_q  <= s1_vs_q;
            s1_rgb_q   <= rgb_in;
        end
    end

    logic hs_edge, vs_edge;
    assign hs_edge = s1_valid_q & s1_hs_q & ~hs_prev_q;
    assign vs_edge = s1_valid_q & s1_vs_q & ~vs_prev_q;

    // ---------------- stage 2: position recovery ----------------
    logic [9:0] hpos_q, vpos_q, hpos_d, vpos_d;
    logic [9:0] fr_h, fr_v;
    logic [2:0] rgb_q, rgb_d;

    always_comb begin
        fr_h = (hpos_q == H_LAST) ? 10'd0 : hpos_q + 10'd1;
        fr_v = vpos_q;
        if (hpos_q == H_LAST) begin
            fr_v = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        rgb_d  = rgb_q;
        if (s1_valid_q) begin
            rgb_d = s1_rgb_q;
            if (vs_edge) begin
                hpos_d = 10'd0;
                vpos_d = V_SYNC;
            end else if (hs_edge) begin
                hpos_d = H_SYNC;
                vpos_d = fr_v;
            end else begin
                hpos_d = fr_h;
                vpos_d = fr_v;
            end
        end
    end

    // Timing errors, all judged against the free-running position.
    logic [TO_W-1:0] to_cnt_q;
    logic line_err, frame_err, timeout_err, err;

    assign line_err    = hs_edge & (fr_h != H_SYNC);
    assign frame_err   = vs_edge & ((fr_h != 10'd0) | (fr_v != V_SYNC));
    assign timeout_err = s1_valid_q & ~hs_edge & (to_cnt_q == TO_MAX);
    assign err         = line_err | frame_err | timeout_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q   <= 10'd0;
            vpos_q   <= 10'd0;
            rgb_q    <= 3'b000;
            to_cnt_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            rgb_q  <= rgb_d;
            if (hs_edge) begin
                to_cnt_q <= '0;
            end else if (s1_valid_q && to_cnt_q <= TO_MAX) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    // ---------------- lock FSM ----------------
    state_e state_q, state_d;
    logic [GOOD_W-1:0] good_q;
    logic locked_st;
    logic lock_lost;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StSearch: begin
                if (vs_edge) state_d = StVerify;
            end
            StVerify: begin
                if (err) begin
                    state_d = StSearch;
                end else if (vs_edge && (good_q + GOOD_W'(1)) == GOOD_LOCK) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (err) state_d = StSearch;
            end
            default: state_d = StSearch;
        endcase
    end

    always_comb begin
        locked_st = (state_q == StLocked);
        lock_lost = (state_q == StLocked) && (state_d != StLocked);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_q <= '0;
        end else if (state_q == StSearch && vs_edge) begin
            good_q <= '0;
        end else if (state_q == StVerify && vs_edge && !err) begin
            good_q <= good_q + GOOD_W'(1);
        end
    end

    // ---------------- error count, frame strobe, ball tracking ----------------
    logic [7:0] err_cnt_q;
    logic       frame_done_q;
    logic       cand_found_q, cand_found_d;
    logic [9:0] cand_x_q, cand_y_q, cand_x_d, cand_y_d;
    logic       ball_valid_q;
    logic [9:0] ball_x_q, ball_y_q;
    logic       capture;

    // Capture decision uses the lock state and position this pixel will be shown with.
    assign capture = s1_valid_q && (state_d == StLocked) && (hpos_d < H_VIS) &&
                     (vpos_d < V_VIS) && (s1_rgb_q == 3'b111);

    always_comb begin
        cand_found_d = cand_found_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        if (vs_edge || lock_lost) begin
            cand_found_d = 1'b0;
        end
        if (capture && !cand_found_d) begin
            cand_found_d = 1'b1;
            cand_x_d     = hpos_d;
            cand_y_d     = vpos_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q    <= 8'd0;
            frame_done_q <= 1'b0;
            cand_found_q <= 1'b0;
            cand_x_q     <= 10'd0;
            cand_y_q     <= 10'd0;
            ball_valid_q <= 1'b0;
            ball_x_q     <= 10'd0;
            ball_y_q     <= 10'd0;
        end else begin
            if (state_q == StLocked && err && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            frame_done_q <= vs_edge && (state_q == StLocked);
            cand_found_q <= cand_found_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            // Losing lock wins over the end-of-frame load; coordinates are kept.
            if (lock_lost) begin
                ball_valid_q <= 1'b0;
            end else if (vs_edge && state_q == StLocked) begin
                ball_valid_q <= cand_found_q;
                ball_x_q     <= cand_x_q;
                ball_y_q     <= cand_y_q;
            end
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign rgb_out    = rgb_q;
    assign locked     = locked_st;
    assign display_on = locked_st && (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign frame_done = frame_done_q;
    assign ball_valid = ball_valid_q;
    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder: a small raster source drives sync and random pixels,
// a reference model predicts each output pixel, and a monitor checks them two clocks later.
module tb_vga_sync_decoder;

    localparam int HT = 40, HV = 32, HSS = 34;
    localparam int VT = 30, VV = 24, VSS = 26;
    localparam int LF = 2, TO = 63, HS_LEN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_in = 1'b0, vsync_in = 1'b0;
    logic [2:0] rgb_in = 3'b000;
    logic [9:0] hpos, vpos, ball_x, ball_y;
    logic [2:0] rgb_out;
    logic       display_on, locked, frame_done, ball_valid;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_VISIBLE(VV), .V_SYNC_START(VSS),
        .SYNC_POL(1), .LOCK_FRAMES(LF), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .hpos(hpos), .vpos(vpos), .rgb_out(rgb_out),
        .display_on(display_on), .locked(locked), .frame_done(frame_done),
        .ball_valid(ball_valid), .ball_x(ball_x), .ball_y(ball_y), .err_count(err_count)
    );

    typedef struct {
        int hp, vp, rgb, disp, lck, fd, bv, bx, by, ec, due;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    bit   tb_done = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- reference model (one call per input sample) ----------------
    int m_h, m_v, m_mode, m_good, m_ec, m_to, m_phs, m_pvs;
    int m_cf, m_cx, m_cy, m_bv, m_bx, m_by;

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 0; m_good = 0; m_ec = 0; m_to = 0;
        m_phs = 0; m_pvs = 0; m_cf = 0; m_cx = 0; m_cy = 0;
        m_bv = 0; m_bx = 0; m_by = 0;
    endtask

    // mode: 0 searching, 1 verifying, 2 locked
    task automatic model_step(input int hs, input int vs, input int rgb, output exp_t e);
        int hs_e, vs_e, fr_h, fr_v, err, was, lost, fd, disp;
        hs_e = (hs == 1 && m_phs == 0);
        vs_e = (vs == 1 && m_pvs == 0);
        m_phs = hs;
        m_pvs = vs;
        fr_h = (m_h + 1) % HT;
        fr_v = (m_h == HT - 1) ? (m_v + 1) % VT : m_v;
        err = (hs_e && fr_h != HSS) || (vs_e && (fr_h != 0 || fr_v != VSS));
        if (hs_e) m_to = 0;
        else if (m_to == TO) begin err = 1; m_to = TO + 1; end
        else if (m_to < TO) m_to = m_to + 1;
        if (vs_e) begin m_h = 0; m_v = VSS; end
        else if (hs_e) begin m_h = HSS; m_v = fr_v; end
        else begin m_h = fr_h; m_v = fr_v; end
        was = (m_mode == 2);
        fd = vs_e && was;
        if (m_mode == 0) begin
            if (vs_e) begin m_mode = 1; m_good = 0; end
        end else if (m_mode == 1) begin
            if (err) m_mode = 0;
            else if (vs_e) begin
                m_good = m_good + 1;
                if (m_good == LF) m_mode = 2;
            end
        end else if (err) begin
            m_mode = 0;
            if (m_ec < 255) m_ec = m_ec + 1;
        end
        lost = was && m_mode != 2;
        if (lost) m_bv = 0;
        else if (fd) begin m_bv = m_cf; m_bx = m_cx; m_by = m_cy; end
        if (vs_e || lost) m_cf = 0;
        disp = (m_mode == 2 && m_h < HV && m_v < VV);
        if (disp && rgb == 7 && m_cf == 0) begin m_cf = 1; m_cx = m_h; m_cy = m_v; end
        e.hp = m_h; e.vp = m_v; e.rgb = rgb; e.disp = disp; e.lck = (m_mode == 2);
        e.fd = fd; e.bv = m_bv; e.bx = m_bx; e.by = m_by; e.ec = m_ec; e.due = 0;
    endtask

    // ---------------- raster source ----------------
    int sh, sv;
    int long_line = -1, gap_lo = -1, gap_hi = -1, vs_shift = 0;
    bit sq_on = 0, wnoise = 0;

    task automatic drive_pixel();
        int   line_len, hs, vs, rgb;
        exp_t e;
        line_len = (sv == long_line) ? HT + 1 : HT;
        hs = (sh >= HSS && sh < HSS + HS_LEN && !(sv >= gap_lo && sv <= gap_hi)) ? 1 : 0;
        vs = ((sv == VSS && sh >= vs_shift) || sv == VSS + 1 ||
              (sv == VSS + 2 && sh < vs_shift)) ? 1 : 0;
        if (sq_on && sh >= 12 && sh < 16 && sv >= 9 && sv < 13) rgb = 7;
        else if (wnoise && $urandom_range(0, 149) == 0) rgb = 7;
        else rgb = int'($urandom_range(0, 6));
        hsync_in = hs[0];
        vsync_in = vs[0];
        rgb_in   = rgb[2:0];
        model_step(hs, vs, rgb, e);
        e.due = edge_cnt + 2;
        sb_q.push_back(e);
        sh = sh + 1;
        if (sh >= line_len) begin sh = 0; sv = (sv + 1) % VT; end
    endtask

    task automatic run(input int n);
        repeat (n) begin @(posedge clk); #1; drive_pixel(); end
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            do begin @(posedge clk); #1; drive_pixel(); end while (!(sh == 0 && sv == 0));
        end
    endtask

    // Reset asserted between clock edges; the first sample is driven right at release.
    task automatic mid_reset(input int cycles);
        @(posedge clk);
        #3;
        reset = 1'b1;
        sb_q.delete();
        model_reset();
        hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = 3'b000;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_pixel();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        sh = int'($urandom_range(0, HT - 1));
        sv = int'($urandom_range(0, VT - 1));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_pixel();
        run_frames(4);                          // acquire lock
        sq_on = 1; run_frames(1);               // white square
        sq_on = 0; run_frames(1);               // no white pixel
        wnoise = 1; run_frames(2); wnoise = 0;  // scattered white pixels
        long_line = 5; run_frames(1); long_line = -1;
        run_frames(4);                          // relock
        sq_on = 1; gap_lo = 3; gap_hi = 6; run_frames(1); gap_lo = -1; gap_hi = -1;
        run_frames(4);                          // recover from timeout
        vs_shift = HSS; run_frames(1); vs_shift = 0;  // hsync and vsync on one sample
        run_frames(4);
        run(int'($urandom_range(200, 900)));
        mid_reset(4);
        run_frames(4);
        run(50);
        tb_done = 1;
    end

    // ---------------- monitor / scoreboard ----------------
    int   n_cmp = 0, n_bad = 0, idle = 0;
    exp_t x;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                n_cmp++;
                if (hpos != 0 || vpos != 0 || rgb_out != 0 || display_on || locked ||
                    frame_done || ball_valid || ball_x != 0 || ball_y != 0 || err_count != 0) begin
                    n_bad++;
                    $display("FAIL reset_state: got hpos=%0d vpos=%0d rgb=%0d disp=%0d lock=%0d fd=%0d bv=%0d bx=%0d by=%0d ec=%0d, expected all zero",
                             hpos, vpos, rgb_out, display_on, locked, frame_done, ball_valid,
                             ball_x, ball_y, err_count);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
                x = sb_q.pop_front();
                n_cmp++;
                if (x.due != edge_cnt) begin
                    n_bad++;
                    $display("FAIL latency: entry due at edge %0d still pending at edge %0d",
                             x.due, edge_cnt);
                end else if (int'(hpos) != x.hp || int'(vpos) != x.vp || int'(rgb_out) != x.rgb ||
                             int'(display_on) != x.disp || int'(locked) != x.lck ||
                             int'(frame_done) != x.fd || int'(ball_valid) != x.bv ||
                             int'(ball_x) != x.bx || int'(ball_y) != x.by ||
                             int'(err_count) != x.ec) begin
                    n_bad++;
                    $display("FAIL pixel@edge%0d: got hpos=%0d vpos=%0d rgb=%0d disp=%0d lock=%0d fd=%0d bv=%0d bx=%0d by=%0d ec=%0d; expected hpos=%0d vpos=%0d rgb=%0d disp=%0d lock=%0d fd=%0d bv=%0d bx=%0d by=%0d ec=%0d",
                             edge_cnt, hpos, vpos, rgb_out, display_on, locked, frame_done,
                             ball_valid, ball_x, ball_y, err_count, x.hp, x.vp, x.rgb, x.disp,
                             x.lck, x.fd, x.bv, x.bx, x.by, x.ec);
                end
            end
            if (tb_done) begin
                idle++;
                if (sb_q.size() == 0 || idle > 10) begin
                    if (sb_q.size() != 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL drain: %0d expected pixels never presented, expected 0",
                                 sb_q.size());
                    end
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                    $finish;
                end
            end
        end
    end

endmodule
